// File: rtl/bnn_test_sequencer.sv
// bnn_test_sequencer: steps test vectors through a combinational BNN classifier; optional scoring under BNN_SEQ_SCORE_EN
module bnn_test_sequencer #(
  parameter int FEAT_CNT = 11,
  parameter int FEAT_BITS = 4,
  parameter int CLASS_CNT = 7,
  parameter int TEST_CNT = 1000,
  parameter int SETTLE_CYCLES = 10,
  localparam int FW = FEAT_CNT * FEAT_BITS,
  localparam int PRED_W = CLASS_CNT > 1 ? $clog2(CLASS_CNT) : 1,
  localparam int ADDR_W = TEST_CNT > 1 ? $clog2(TEST_CNT) : 1,
  localparam int CNT_W = $clog2(TEST_CNT + 1),
  localparam int SET_W = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [FW-1:0]     mem_data,
  input  logic [PRED_W-1:0] exp_label,
  output logic [FW-1:0]     features,
  input  logic [PRED_W-1:0] prediction,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PRED_W-1:0] pred_out,
  output logic [ADDR_W-1:0] pred_idx,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  correct_cnt
);
  typedef enum logic [2:0] {IDLE, FETCH, SETTLE, CAPTURE, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TEST_CNT - 1);
  state_t state, next;
  logic [ADDR_W-1:0] idx;
  logic [SET_W-1:0] settle;
  logic hs;
  assign hs = state == CAPTURE && out_ready;
  assign mem_addr = idx;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  // next-state logic
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? FETCH : IDLE;
      FETCH:   next = SETTLE;
      SETTLE:  next = settle == '0 ? CAPTURE : SETTLE;
      CAPTURE: next = out_ready ? (idx == LAST ? DONE : FETCH) : CAPTURE;
      default: next = IDLE;
    endcase
  end
  // vector index, classifier drive and captured result
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx <= '0;
      settle <= '0;
      features <= '0;
      pred_out <= '0;
      pred_idx <= '0;
      out_valid <= 1'b0;
    end else begin
      if (state == IDLE && start) idx <= '0;
      if (state == FETCH) begin
        features <= mem_data;
        settle <= SET_W'(SETTLE_CYCLES - 1);
      end
      if (state == SETTLE) begin
        if (settle != '0) settle <= settle - 1'b1;
        else begin
          pred_out <= prediction;
          pred_idx <= idx;
          out_valid <= 1'b1;
        end
      end
      if (hs) begin
        out_valid <= 1'b0;
        if (idx != LAST) idx <= idx + 1'b1;
      end
    end
`ifdef BNN_SEQ_SCORE_EN
  logic [PRED_W-1:0] label_r;
  // expected label tracking and match counting
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      label_r <= '0;
      correct_cnt <= '0;
    end else begin
      if (state == IDLE && start) correct_cnt <= '0;
      if (state == FETCH) label_r <= exp_label;
      if (hs && prediction == label_r) correct_cnt <= correct_cnt + CNT_W'(1);
    end
`else
  logic unused_label;
  assign unused_label = ^exp_label;
  assign correct_cnt = '0;
`endif
endmodule

// File: doc/bnn_test_sequencer.md
BNN_TEST_SEQUENCER -- requirements
Module: bnn_test_sequencer

Interface
REQ-001 SHALL have parameter FEAT_CNT, default 11, number of input features per test vector.
REQ-002 SHALL have parameter FEAT_BITS, default 4, bits per feature.
REQ-003 SHALL have parameter CLASS_CNT, default 7, classifier output classes; PRED_W = $clog2(CLASS_CNT).
REQ-004 SHALL have parameter TEST_CNT, default 1000, vectors per run, at least 1; ADDR_W = $clog2(TEST_CNT), CNT_W = $clog2(TEST_CNT+1).
REQ-005 SHALL have parameter SETTLE_CYCLES, default 10, classifier settle time in clocks, at least 1.
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port start, input, 1, a one-cycle request to begin a run.
REQ-009 SHALL have port mem_addr, output, ADDR_W, test-vector memory address.
REQ-010 SHALL have port mem_data, input, FEAT_CNT*FEAT_BITS, vector read at mem_addr, valid one cycle after the address.
REQ-011 SHALL have port exp_label, input, PRED_W, expected class at mem_addr, with the same latency as mem_data.
REQ-012 SHALL have port features, output, FEAT_CNT*FEAT_BITS, registered drive to the combinational classifier.
REQ-013 SHALL have port prediction, input, PRED_W, the classifier result.
REQ-014 SHALL have port out_valid, input ready pair: out_valid output 1, out_ready input 1.
REQ-015 SHALL have port pred_out, output, PRED_W, the captured prediction.
REQ-016 SHALL have port pred_idx, output, ADDR_W, the index of that captured prediction.
REQ-017 SHALL have port busy, output, 1, high outside IDLE.
REQ-018 SHALL have port done, output, 1, one-cycle pulse at the end of a run.
REQ-019 SHALL have port correct_cnt, output, CNT_W, the count of matching predictions.

Function
REQ-020 SHALL implement FSM states IDLE, FETCH, SETTLE, CAPTURE, DONE.
REQ-021 IDLE: on start, SHALL set idx=0, mem_addr=0, clear correct_cnt, and go to FETCH; start in any other state SHALL be ignored.
REQ-022 FETCH: SHALL last exactly 1 cycle; on exit SHALL load features<=mem_data and label_r<=exp_label, set settle counter to SETTLE_CYCLES-1, and go to SETTLE.
REQ-023 SETTLE: SHALL decrement the counter each cycle and go to CAPTURE when the counter is 0, giving exactly SETTLE_CYCLES cycles of stable features.
REQ-024 CAPTURE entry: SHALL register pred_out<=prediction and pred_idx<=idx, and raise out_valid.
REQ-025 out_valid, pred_out and pred_idx SHALL hold stable until a cycle with out_ready=1.
REQ-026 On that handshake cycle: if idx==TEST_CNT-1, SHALL go to DONE; otherwise SHALL set idx++, mem_addr=idx+1, and go to FETCH.
REQ-027 out_valid SHALL drop the cycle after the handshake.
REQ-028 out_ready held high SHALL give one result per SETTLE_CYCLES+2 clocks.
REQ-029 features SHALL remain unchanged during SETTLE and CAPTURE, including while stalled on out_ready.
REQ-030 DONE: SHALL assert done for 1 cycle, then go to IDLE; correct_cnt SHALL be retained until the next start.
REQ-031 With TEST_CNT=1, the run SHALL be a single FETCH/SETTLE/CAPTURE pass, then DONE.
REQ-032 mem_addr SHALL never exceed TEST_CNT-1.

Reset
REQ-033 rst=1 SHALL force IDLE immediately, asynchronously, including mid-run.
REQ-034 Under rst, all outputs (mem_addr, features, out_valid, pred_out, pred_idx, busy, done, correct_cnt), idx and the settle counter SHALL be 0.
REQ-035 After rst, no partial result SHALL be emitted and a new start SHALL be required.

Configuration
REQ-036 With BNN_SEQ_SCORE_EN defined: on each CAPTURE handshake, if prediction equals label_r, correct_cnt SHALL increment by 1 (saturation is unreachable; its maximum is TEST_CNT).
REQ-037 Without BNN_SEQ_SCORE_EN: correct_cnt SHALL be constant 0, exp_label SHALL be ignored, no label register SHALL be present, and the port list SHALL stay unchanged.

Verification
REQ-038 TEST_CNT=4, SETTLE_CYCLES=3, out_ready=1, start pulse -> 4 out_valid pulses spaced 5 clocks apart, pred_idx 0,1,2,3, then done for 1 cycle and busy low.
REQ-039 Classifier model returning mem_data[2:0]; memory word 0x5, label 5 -> pred_out=5 and, with BNN_SEQ_SCORE_EN, correct_cnt=1 after vector 0.
REQ-040 Hold out_ready=0 for 7 cycles during the vector-1 CAPTURE -> out_valid, pred_out and features stable for all 7 cycles, then exactly one handshake and mem_addr advances to 2.
REQ-041 Assert rst in SETTLE of vector 2 -> next cycle all outputs 0 and state IDLE; a later start restarts at pred_idx 0 with correct_cnt 0.
REQ-042 start pulsed during busy -> no effect on idx or sequencing.
REQ-043 With labels all matching except index 1, run TEST_CNT=4 -> correct_cnt=3 when BNN_SEQ_SCORE_EN is defined, 0 when it is not.
